// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
// Holds the FSM state encoding and the default counter width.
package clk_mon_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus edge detector for an asynchronous input.
// Ports: clk_in, rst (sync, active-high), sig_in -> rise_det, fall_det.
module sync_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise_det,
    output logic fall_det
);

    logic [1:0] sync_q;
    logic       edge_q;
    logic       rise_q;
    logic       fall_q;

    // edge_q holds the previous synchronized level; the pulses are
    // registered so downstream logic sees clean single-cycle strobes.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sig_in};
            edge_q <= sync_q[1];
            rise_q <= sync_q[1] & ~edge_q;
            fall_q <= ~sync_q[1] & edge_q;
        end
    end

    assign rise_det = rise_q;
    assign fall_det = fall_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock against expectations.
// Ports: clk_in, rst, sig_in, meas_en, exp_period, exp_high ->
//        period, high_time, meas_valid, match, overflow, err_count.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOL   = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_en,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] exp_high,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             match,
    output logic             overflow,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAXV  = '1;
    localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);

    logic             rise_det;
    logic             fall_det;
    state_e           state_q;
    logic [CNT_W-1:0] period_cnt_q;
    logic [CNT_W-1:0] high_cnt_q;
    logic             en_q;

    logic [CNT_W-1:0] hdiff_d;
    logic             match_d;
    logic             close_d;
    logic             ovf_d;
    logic             err_inc_d;

    sync_edge_det u_sync (
        .clk_in   (clk_in),
        .rst      (rst),
        .sig_in   (sig_in),
        .rise_det (rise_det),
        .fall_det (fall_det)
    );

    // Absolute difference without wrap: larger minus smaller.
    always_comb begin
        hdiff_d = '0;
        if (high_cnt_q >= exp_high) hdiff_d = high_cnt_q - exp_high;
        else                        hdiff_d = exp_high - high_cnt_q;
    end

    assign match_d = (period_cnt_q == exp_period) && (hdiff_d <= TOL_V);

    // A closing rise and a counter overflow are mutually exclusive here,
    // so err_inc_d never asks for more than one increment per cycle.
    always_comb begin
        close_d = 1'b0;
        ovf_d   = 1'b0;
        if (meas_en) begin
            unique case (state_q)
                MEAS_HIGH: ovf_d = (period_cnt_q == MAXV);
                MEAS_LOW: begin
                    close_d = rise_det;
                    ovf_d   = !rise_det && (period_cnt_q == MAXV);
                end
                default: ;
            endcase
        end
    end

    assign err_inc_d = ovf_d || (close_d && !match_d);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            en_q         <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            meas_valid   <= 1'b0;
            match        <= 1'b0;
            overflow     <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            en_q       <= meas_en;
            meas_valid <= 1'b0;

            if (meas_en && !en_q) overflow <= 1'b0;
            if (ovf_d)            overflow <= 1'b1;
            if (err_inc_d && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end

            if (!meas_en) begin
                state_q      <= IDLE;
                period_cnt_q <= '0;
                high_cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= ARM;
                    ARM: begin
                        if (rise_det) begin
                            state_q      <= MEAS_HIGH;
                            period_cnt_q <= ONE;
                            high_cnt_q   <= ONE;
                        end
                    end
                    MEAS_HIGH: begin
                        if (ovf_d) begin
                            state_q <= ARM;
                        end else begin
                            period_cnt_q <= period_cnt_q + ONE;
                            if (fall_det) state_q    <= MEAS_LOW;
                            else          high_cnt_q <= high_cnt_q + ONE;
                        end
                    end
                    MEAS_LOW: begin
                        if (close_d) begin
                            period       <= period_cnt_q;
                            high_time    <= high_cnt_q;
                            match        <= match_d;
                            meas_valid   <= 1'b1;
                            period_cnt_q <= ONE;
                            high_cnt_q   <= ONE;
                            state_q      <= MEAS_HIGH;
                        end else if (ovf_d) begin
                            state_q <= ARM;
                        end else begin
                            period_cnt_q <= period_cnt_q + ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of all cycle counters and measurement outputs.
REQ-002 Parameter TOL, default 1: allowed high-time deviation in clk_in cycles.
REQ-003 clk_in  input  1  reference clock; all logic SHALL sample on posedge clk_in.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 sig_in  input  1  divided clock under test; treated as asynchronous.
REQ-006 meas_en  input  1  enables measurement; low forces IDLE.
REQ-007 exp_period  input  CNT_W  expected period in clk_in cycles.
REQ-008 exp_high  input  CNT_W  expected high time in clk_in cycles.
REQ-009 period  output  CNT_W  last measured rise-to-rise cycle count.
REQ-010 high_time  output  CNT_W  last measured rise-to-fall cycle count.
REQ-011 meas_valid  output  1  one-cycle strobe when period/high_time/match update.
REQ-012 match  output  1  last measurement within expectation.
REQ-013 overflow  output  1  sticky; set on counter saturation without edge.
REQ-014 err_count  output  8  saturating count of mismatches plus overflows.

Function
REQ-015 sig_in SHALL pass a 2-flop synchronizer then a 1-flop edge detector producing rise_det/fall_det single-cycle pulses.
REQ-016 FSM states: IDLE, ARM, MEAS_HIGH, MEAS_LOW.
REQ-017 IDLE -> ARM when meas_en=1; any state -> IDLE when meas_en=0, clearing internal counters, holding outputs.
REQ-018 ARM -> MEAS_HIGH on rise_det, loading period_cnt=1 and high_cnt=1; no meas_valid on this first edge.
REQ-019 MEAS_HIGH: period_cnt and high_cnt increment each cycle; on fall_det -> MEAS_LOW, high_cnt frozen.
REQ-020 MEAS_LOW: period_cnt increments; on rise_det latch period<=period_cnt, high_time<=high_cnt, pulse meas_valid, reload counters to 1, -> MEAS_HIGH.
REQ-021 Result: sig_in with N-cycle period, H-cycle high time SHALL yield period=N, high_time=H.
REQ-022 Latency: meas_valid SHALL assert exactly 3 clk_in cycles after the first clk_in edge that samples closing sig_in rise high.
REQ-023 match SHALL equal (period==exp_period) AND (|high_time-exp_high| <= TOL), updated with meas_valid.
REQ-024 Difference SHALL be computed unsigned without wrap (larger minus smaller).
REQ-025 If period_cnt reaches 2^CNT_W-1 without closing rise: overflow<=1, err_count increments, no meas_valid, FSM -> ARM.
REQ-026 err_count SHALL increment on meas_valid with match=0, saturate at 255, never wrap.
REQ-027 Overflow and mismatch same cycle impossible; if both indicated, err_count increments once.
REQ-028 overflow SHALL clear only on rst or meas_en 0->1 transition.
REQ-029 exp_period/exp_high SHALL be sampled only in the meas_valid cycle; changes mid-period have no other effect.

Reset
REQ-030 On rst: FSM=IDLE, synchronizer and edge flops=0, period=0, high_time=0, meas_valid=0, match=0, overflow=0, err_count=0.
REQ-031 rst mid-measurement SHALL discard the partial period; first meas_valid after release requires two rises.
REQ-032 rst SHALL take priority over meas_en and all edge events.

Structure
REQ-033 Package clk_mon_pkg SHALL hold the FSM state enum and CNT_W default constant.
REQ-034 Sub-module sync_edge_det SHALL implement the synchronizer and rise/fall pulse generation.
REQ-035 Target size 150-300 lines RTL; no sig_in used as a clock.

Verification
REQ-036 sig_in=clk_div_4 of clock generator, exp_period=4, exp_high=2 -> meas_valid every 4 cycles, period=4, high_time=2, match=1.
REQ-037 sig_in=clk_div_28, exp_period=28, exp_high=14 -> period=28, high_time=14, match=1, err_count=0.
REQ-038 sig_in=clk_div_5 (non-50% duty), exp_period=5, exp_high=2, TOL=1 -> period=5, high_time in {2,3}, match=1.
REQ-039 sig_in held 0 after one rise, CNT_W=8 -> overflow=1 when count hits 255, err_count=1, no meas_valid.
REQ-040 clk_div_8 with exp_period=7 for 300 strobes -> match=0 each strobe, err_count saturates at 255.
REQ-041 rst pulse mid-MEAS_LOW -> all outputs 0 next cycle; first meas_valid only after second subsequent rise.
